// File: rtl/keypad_scanner.sv
// keypad_scanner: 5x4 matrix keypad scanner with press/release debounce and ghost rejection.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DWELL      = 1000,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [4:0] cols,
    output logic       newkey,
    output logic [4:0] keycode,
    output logic       keydown
);

    localparam int MAX_A = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
    localparam int MAX_B = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DWELL - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST    = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST    = CW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    sync1, sync2;
    logic [2:0]    col, col_nx, col_adv;
    logic [CW-1:0] dwell, dwell_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    pat, pat_nx;
    logic [1:0]    row, row_nx;
    logic          newkey_nx, keydown_nx;
    logic [4:0]    keycode_nx;
    logic [2:0]    low_cnt;
    logic [1:0]    low_idx;
`ifdef KEYPAD_REPEAT_EN
    logic [CW-1:0] rep, rep_nx;
    logic          rep_first, rep_first_nx;
`endif

    assign cols    = ~(5'd1 << col);
    assign col_adv = (col == 3'd4) ? 3'd0 : col + 3'd1;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
        end else begin
            sync1 <= rows;
            sync2 <= sync1;
        end
    end

    // Count low rows and remember the index of the last one found.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (!sync2[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_idx = 2'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col       <= '0;
            dwell     <= '0;
            cnt       <= '0;
            pat       <= 4'hF;
            row       <= '0;
            newkey    <= 1'b0;
            keycode   <= '0;
            keydown   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            dwell     <= dwell_nx;
            cnt       <= cnt_nx;
            pat       <= pat_nx;
            row       <= row_nx;
            newkey    <= newkey_nx;
            keycode   <= keycode_nx;
            keydown   <= keydown_nx;
`ifdef KEYPAD_REPEAT_EN
            rep       <= rep_nx;
            rep_first <= rep_first_nx;
`endif
        end
    end

    // Next-state logic: scan, debounce press, hold, debounce release.
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        dwell_nx   = dwell;
        cnt_nx     = cnt;
        pat_nx     = pat;
        row_nx     = row;
        newkey_nx  = 1'b0;
        keycode_nx = keycode;
        keydown_nx = keydown;
`ifdef KEYPAD_REPEAT_EN
        rep_nx       = rep;
        rep_first_nx = rep_first;
`endif
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    if (low_cnt == 3'd1) begin
                        pat_nx   = sync2;
                        row_nx   = low_idx;
                        cnt_nx   = '0;
                        state_nx = PRESS_DB;
                    end else begin
                        col_nx = col_adv;
                    end
                end else begin
                    dwell_nx = dwell + CW'(1);
                end
            end
            PRESS_DB: begin
                if (sync2 != pat) begin
                    cnt_nx   = '0;
                    state_nx = SCAN;
                end else if (cnt == DB_LAST) begin
                    newkey_nx  = 1'b1;
                    keycode_nx = {col, row};
                    keydown_nx = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HELD: begin
                if (sync2 == 4'hF) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE_DB;
`ifdef KEYPAD_REPEAT_EN
                    rep_nx   = '0;
                end else if (rep == (rep_first ? RD_LAST : RP_LAST)) begin
                    newkey_nx    = 1'b1;
                    rep_nx       = '0;
                    rep_first_nx = 1'b0;
                end else begin
                    rep_nx = rep + CW'(1);
`endif
                end
            end
            RELEASE_DB: begin
                if (sync2 != 4'hF) begin
                    cnt_nx   = '0;
                    state_nx = HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_nx       = '0;
                    rep_first_nx = 1'b1;
`endif
                end else if (cnt == DB_LAST) begin
                    keydown_nx = 1'b0;
                    cnt_nx     = '0;
                    dwell_nx   = '0;
                    col_nx     = col_adv;
                    state_nx   = SCAN;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = SCAN;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model, vector table, random presses with a reference model.
// Repeat expectations follow KEYPAD_REPEAT_EN when it is defined for the build.
module tb_keypad_scanner;

    localparam int DW = 4;
    localparam int DB = 8;
    localparam int RD = 20;
    localparam int RP = 10;
    localparam int LAT_MAX = 2 + 5 * DW + DB + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [4:0]  cols;
    logic        newkey;
    logic [4:0]  keycode;
    logic        keydown;
    logic [19:0] pressed = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dbl      = 0;
    logic prev_nk = 1'b0;
    int q_code[$];
    int q_t[$];

    typedef struct {
        logic [19:0] keys;
        int          bounces;
        int          exp_n;
        int          exp_code;
    } vec_t;

    vec_t tbl[7];

    always #5 clock = ~clock;

    keypad_scanner #(
        .SCAN_DWELL(DW),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .newkey(newkey),
        .keycode(keycode),
        .keydown(keydown)
    );

    // Passive matrix: a pressed key pulls its row low when its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (!cols[c] && pressed[c*4+r]) rows[r] = 1'b0;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Record every newkey pulse with its cycle stamp.
    always @(negedge clock) begin
        if (reset && newkey) begin
            q_code.push_back(int'(keycode));
            q_t.push_back(cyc);
        end
        if (newkey && prev_nk) dbl++;
        prev_nk = newkey;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_pulses(input string nm, input int t_on,
                                input int exp_n, input int exp_code);
`ifdef KEYPAD_REPEAT_EN
        if (exp_n == 0) chk({nm, " pulses"}, q_code.size(), 0);
        else chk({nm, " pulses>=n"}, int'(q_code.size() >= exp_n), 1);
        for (int k = 1; k < q_t.size(); k++)
            chk({nm, " repeat spacing"}, q_t[k] - q_t[0], RD + (k - 1) * RP);
`else
        chk({nm, " pulses"}, q_code.size(), exp_n);
`endif
        for (int k = 0; k < q_code.size(); k++)
            chk({nm, " code"}, q_code[k], exp_code);
        if (q_t.size() > 0) begin
            chk({nm, " latency min"}, int'(q_t[0] - t_on >= DB), 1);
            chk({nm, " latency max"}, int'(q_t[0] - t_on <= LAT_MAX), 1);
        end
    endtask

    task automatic press_key(input logic [19:0] keys, input int bounces, input int gap,
                             input int hold, input int rel_b, input int exp_n,
                             input int exp_code, input string nm);
        int t_on;
        q_code.delete();
        q_t.delete();
        @(negedge clock);
        for (int b = 0; b < bounces; b++) begin
            pressed = keys;
            repeat (gap) @(negedge clock);
            pressed = '0;
            repeat (gap) @(negedge clock);
        end
        pressed = keys;
        t_on = cyc;
        repeat (hold) @(negedge clock);
        chk({nm, " keydown held"}, keydown, int'(exp_n > 0));
        for (int b = 0; b < rel_b; b++) begin
            pressed = '0;
            repeat (gap) @(negedge clock);
            pressed = keys;
            repeat (gap) @(negedge clock);
        end
        pressed = '0;
        repeat (DB - 1) @(negedge clock);
        chk({nm, " keydown early"}, keydown, int'(exp_n > 0));
        repeat (DB + 7) @(negedge clock);
        chk({nm, " keydown released"}, keydown, 0);
        check_pulses(nm, t_on, exp_n, exp_code);
        if (exp_n > 0) chk({nm, " keycode held"}, keycode, exp_code);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0]  e;
        logic [19:0] keys;
        int c, r, r2, g, run, found, rep_n;

        tbl[0] = '{20'h00200, 0, 1, 9};
        tbl[1] = '{20'h80000, 0, 1, 19};
        tbl[2] = '{20'h00001, 1, 1, 0};
        tbl[3] = '{20'h00010, 2, 1, 4};
        tbl[4] = '{20'h00090, 0, 0, 0};
        tbl[5] = '{20'h04000, 0, 1, 14};
        tbl[6] = '{20'h00500, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset cols", cols, 5'b11110);
        chk("reset newkey", newkey, 0);
        chk("reset keycode", keycode, 0);
        chk("reset keydown", keydown, 0);

        // Idle scan
        reset = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clock);
            e = ~(5'd1 << ((i / 4) % 5));
            chk($sformatf("idle cols i=%0d", i), cols, e);
        end
        chk("idle no newkey", q_code.size(), 0);

        // Table of single keys and ghosts
        for (int i = 0; i < 7; i++)
            press_key(tbl[i].keys, tbl[i].bounces, 3, 40, 0,
                      tbl[i].exp_n, tbl[i].exp_code, $sformatf("tbl%0d", i));

        // Bouncing press and release on col1/row0
        press_key(20'h00010, 5, 3, 40, 5, 1, 4, "bounce");

        // Randomized presses against the reference model
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(4);
            r = $urandom_range(3);
            g = int'($urandom_range(3) == 0);
            keys = 20'd1 << (c * 4 + r);
            if (g != 0) begin
                r2 = (r + 1 + $urandom_range(2)) % 4;
                keys = keys | (20'd1 << (c * 4 + r2));
            end
            press_key(keys, $urandom_range(4), $urandom_range(5, 1),
                      $urandom_range(60, 35), $urandom_range(3),
                      (g != 0) ? 0 : 1, c * 4 + r, $sformatf("rnd%0d", it));
        end

        // Col4/row3 then reset during press debounce of the next key
        press_key(20'h80000, 0, 3, 40, 0, 1, 19, "pre-reset");
        q_code.delete();
        q_t.delete();
        pressed = 20'h00002;
        run = 0;
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            @(negedge clock);
            if (cols == 5'b11110) run++;
            else run = 0;
            if (run >= 6) found = 1;
        end
        chk("reset prep reached", found, 1);
        reset = 1'b0;
        #1;
        chk("async reset cols", cols, 5'b11110);
        chk("async reset newkey", newkey, 0);
        chk("async reset keycode", keycode, 0);
        chk("async reset keydown", keydown, 0);
        pressed = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("in reset cols", cols, 5'b11110);
            chk("in reset newkey", newkey, 0);
        end
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("reset discards key", q_code.size(), 0);
        chk("reset keydown after", keydown, 0);

        // Long hold of col0/row2
`ifdef KEYPAD_REPEAT_EN
        rep_n = 4;
`else
        rep_n = 1;
`endif
        press_key(20'h00004, 0, 3, 100, 0, rep_n, 2, "hold");

        chk("no back-to-back newkey", dbl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
